// File: rtl/bcd_display_pkg.sv
// Shared types and constants for the BCD seven-segment scan driver.
// Segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
package bcd_display_pkg;

    typedef logic [6:0] seg_t;

    // Capture register layout: 1 + 3*4 = 13 bits.
    typedef struct packed {
        logic       thousands;
        logic [3:0] hundreds;
        logic [3:0] tens;
        logic [3:0] ones;
    } digits_t;

    localparam seg_t SEG_0     = 7'b1000000;
    localparam seg_t SEG_1     = 7'b1111001;
    localparam seg_t SEG_2     = 7'b0100100;
    localparam seg_t SEG_3     = 7'b0110000;
    localparam seg_t SEG_4     = 7'b0011001;
    localparam seg_t SEG_5     = 7'b0010010;
    localparam seg_t SEG_6     = 7'b0000010;
    localparam seg_t SEG_7     = 7'b1111000;
    localparam seg_t SEG_8     = 7'b0000000;
    localparam seg_t SEG_9     = 7'b0010000;
    localparam seg_t SEG_DASH  = 7'b0111111;
    localparam seg_t SEG_BLANK = 7'b1111111;

    localparam logic [3:0] AN_OFF = 4'b1111;

    // Digit selected for a scan slot; thousands is zero-extended.
    function automatic logic [3:0] digit_at(input digits_t d, input logic [1:0] idx);
        logic [3:0] digit;
        case (idx)
            2'd0:    digit = d.ones;
            2'd1:    digit = d.tens;
            2'd2:    digit = d.hundreds;
            default: digit = {3'b000, d.thousands};
        endcase
        return digit;
    endfunction

endpackage

// File: rtl/bcd_to_seg_decoder.sv
// Combinational BCD to active-low seven-segment decoder.
// Codes 10-15 render as a dash so bad converter output is visible.
module bcd_to_seg_decoder
    import bcd_display_pkg::*;
(
    input  logic [3:0] bcd_i,
    output seg_t       seg_o
);

    always_comb begin
        seg_o = SEG_DASH;
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_seven_segment_scan.sv
// Four-digit common-anode scan driver: captures BCD digits on load and
// multiplexes them, CLK_DIV cycles per digit. Optional BCD_SCAN_LEADING_ZERO_BLANK_EN.
module bcd_seven_segment_scan
    import bcd_display_pkg::*;
#(
    parameter int CLK_DIV = 100000,
    parameter int CNT_W   = $clog2(CLK_DIV)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] ones,
    input  logic [3:0] tens,
    input  logic [3:0] hundreds,
    input  logic       thousands,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    digits_t          cap_q, cap_d;
    logic [3:0]       an_q, an_d;
    seg_t             seg_q, seg_d;

    logic             cnt_wrap;
    logic [3:0]       digit_sel;
    seg_t             seg_dec;
    logic [3:0]       blank_vec;
    logic             blank_sel;

    assign cnt_wrap = (cnt_q == CNT_W'(CLK_DIV - 1));
    assign cnt_d    = cnt_wrap ? '0 : cnt_q + CNT_W'(1);
    assign idx_d    = cnt_wrap ? idx_q + 2'd1 : idx_q;
    assign cap_d    = load ? '{thousands: thousands, hundreds: hundreds, tens: tens, ones: ones}
                           : cap_q;

    assign digit_sel = digit_at(cap_q, idx_q);

    bcd_to_seg_decoder u_decoder (
        .bcd_i (digit_sel),
        .seg_o (seg_dec)
    );

`ifdef BCD_SCAN_LEADING_ZERO_BLANK_EN
    // A digit blanks only if it and every higher digit are zero; ones never blanks.
    logic zero_th, zero_hu, zero_te;
    assign zero_th   = ~cap_q.thousands;
    assign zero_hu   = zero_th & (cap_q.hundreds == 4'd0);
    assign zero_te   = zero_hu & (cap_q.tens == 4'd0);
    assign blank_vec = {zero_th, zero_hu, zero_te, 1'b0};
`else
    assign blank_vec = 4'b0000;
`endif

    assign blank_sel = blank_vec[idx_q];
    assign seg_d     = blank_sel ? SEG_BLANK : seg_dec;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_anode
            assign an_d[gi] = blank_sel | (idx_q != 2'(gi));
        end
    endgenerate

    // Outputs use the pre-edge idx/capture so an and seg move together.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            idx_q <= 2'd0;
            cap_q <= '0;
            an_q  <= AN_OFF;
            seg_q <= SEG_BLANK;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            cap_q <= cap_d;
            an_q  <= an_d;
            seg_q <= seg_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = 1'b1;

endmodule

// File: tb/tb_bcd_seven_segment_scan.sv
// Directed bench for bcd_seven_segment_scan with CLK_DIV=4; expectations
// follow BCD_SCAN_LEADING_ZERO_BLANK_EN when it is defined.
module tb_bcd_seven_segment_scan;

    localparam int CLK_DIV = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       load = 1'b0;
    logic [3:0] ones = 4'd0;
    logic [3:0] tens = 4'd0;
    logic [3:0] hundreds = 4'd0;
    logic       thousands = 1'b0;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int vectors = 0;
    int miscompares = 0;

    // Hand-computed constants.
    logic [3:0] scan_an   [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    // Value 1,2,3,4 -> slots show 4,3,2,1.
    logic [6:0] scan_seg  [4] = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};
    // Value 0,0,4,2 -> slots show 2,4, then blank or 0.
`ifdef BCD_SCAN_LEADING_ZERO_BLANK_EN
    logic [3:0] lz_an     [4] = '{4'b1110, 4'b1101, 4'b1111, 4'b1111};
    logic [6:0] lz_seg    [4] = '{7'b0100100, 7'b0011001, 7'b1111111, 7'b1111111};
    logic [3:0] zero_an   [4] = '{4'b1110, 4'b1111, 4'b1111, 4'b1111};
    logic [6:0] zero_seg  [4] = '{7'b1000000, 7'b1111111, 7'b1111111, 7'b1111111};
`else
    logic [3:0] lz_an     [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [6:0] lz_seg    [4] = '{7'b0100100, 7'b0011001, 7'b1000000, 7'b1000000};
    logic [3:0] zero_an   [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [6:0] zero_seg  [4] = '{7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000};
`endif

    always #5 clk = ~clk;

    bcd_seven_segment_scan #(.CLK_DIV(CLK_DIV)) dut (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .ones      (ones),
        .tens      (tens),
        .hundreds  (hundreds),
        .thousands (thousands),
        .an        (an),
        .seg       (seg),
        .dp        (dp)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        vectors++;
        assert (obs === exp) begin
            $display("vec %0d %s: observed %b expected %b ok", vectors, tag, obs, exp);
        end else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic set_digits(input logic th, input logic [3:0] hu, input logic [3:0] te,
                              input logic [3:0] on);
        thousands = th;
        hundreds  = hu;
        tens      = te;
        ones      = on;
    endtask

    // Release reset with load high so the capture takes effect on edge 1.
    task automatic release_with_load();
        load  = 1'b1;
        reset = 1'b0;
        tick();
        load  = 1'b0;
    endtask

    initial begin
        int slot;

        // Reset held three cycles
        reset = 1'b1;
        repeat (3) tick();
        check("reset_an", 7'(an), 7'(4'b1111));
        check("reset_seg", seg, 7'b1111111);
        check("reset_dp", 7'(dp), 7'd1);

        // Release: first edge shows digit 0 in slot 0
        reset = 1'b0;
        tick();
        check("release_an", 7'(an), 7'(4'b1110));
        check("release_seg", seg, 7'b1000000);

        // Scan order with 1,2,3,4
        reset = 1'b1;
        tick();
        set_digits(1'b1, 4'd2, 4'd3, 4'd4);
        release_with_load();
        check("scan_e1_an", 7'(an), 7'(4'b1110));
        check("scan_e1_seg", seg, 7'b1000000);
        for (int k = 2; k <= 17; k++) begin
            tick();
            slot = ((k - 1) / 4) % 4;
            check($sformatf("scan_e%0d_an", k), 7'(an), 7'(scan_an[slot]));
            check($sformatf("scan_e%0d_seg", k), seg, scan_seg[slot]);
        end

        // Load latency during slot 0 (edge 18 captures, edge 19 shows)
        set_digits(1'b1, 4'd2, 4'd3, 4'd9);
        load = 1'b1;
        tick();
        load = 1'b0;
        check("lat_e18_seg_old", seg, 7'b0011001);
        tick();
        check("lat_e19_seg_new", seg, 7'b0010000);
        check("lat_e19_an", 7'(an), 7'(4'b1110));

        // Inputs change without load: no effect
        set_digits(1'b0, 4'd8, 4'd8, 4'd5);
        tick();
        check("hold_e20_seg", seg, 7'b0010000);
        tick();
        check("hold_e21_an", 7'(an), 7'(4'b1101));
        check("hold_e21_seg", seg, 7'b0110000);

        // Invalid BCD in tens
        set_digits(1'b1, 4'd3, 4'd12, 4'd9);
        load = 1'b1;
        tick();
        load = 1'b0;
        check("dash_e22_seg_old", seg, 7'b0110000);
        tick();
        check("dash_e23_seg", seg, 7'b0111111);
        check("dash_e23_an", 7'(an), 7'(4'b1101));

        // Load coinciding with counter wrap (edge 24)
        set_digits(1'b1, 4'd7, 4'd12, 4'd9);
        load = 1'b1;
        tick();
        load = 1'b0;
        check("wrap_e24_seg", seg, 7'b0111111);
        tick();
        check("wrap_e25_an", 7'(an), 7'(4'b1011));
        check("wrap_e25_seg", seg, 7'b1111000);

        // Mid-scan reset in cycle 2 of slot 2
        reset = 1'b1;
        tick();
        check("midrst_an", 7'(an), 7'(4'b1111));
        check("midrst_seg", seg, 7'b1111111);
        check("midrst_dp", 7'(dp), 7'd1);
        reset = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            check($sformatf("midrst_f%0d_an", k), 7'(an), (k <= 4) ? 7'(4'b1110) : 7'(4'b1101));
            if (k == 1)
                check("midrst_f1_seg_cleared", seg, 7'b1000000);
        end

        // Leading zeros: value 0,0,4,2
        reset = 1'b1;
        tick();
        set_digits(1'b0, 4'd0, 4'd4, 4'd2);
        release_with_load();
        for (int k = 2; k <= 16; k++) begin
            tick();
            slot = ((k - 1) / 4) % 4;
            check($sformatf("lz_e%0d_an", k), 7'(an), 7'(lz_an[slot]));
            check($sformatf("lz_e%0d_seg", k), seg, lz_seg[slot]);
        end

        // Value zero: only ones lit when blanking is enabled
        reset = 1'b1;
        tick();
        set_digits(1'b0, 4'd0, 4'd0, 4'd0);
        release_with_load();
        for (int k = 2; k <= 16; k++) begin
            tick();
            slot = ((k - 1) / 4) % 4;
            check($sformatf("zero_e%0d_an", k), 7'(an), 7'(zero_an[slot]));
            check($sformatf("zero_e%0d_seg", k), seg, zero_seg[slot]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
